// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding and default width for the serial subtractor
package sub_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit x - y - bin cell producing difference and borrow
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, bout_q, bout_d;
    logic             d_bit, br_nx;

    full_subtractor u_fs (
        .x   (a_q[0]),
        .y   (b_q[0]),
        .bin (br_q),
        .d   (d_bit),
        .bout(br_nx)
    );

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign busy  = state_q == SHIFT;
    assign done  = state_q == DONE;
    assign diff  = diff_q;
    assign bout  = bout_q;

    // next state: capture operands when ready, otherwise shift one bit per cycle
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = start ? SHIFT : IDLE;
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    br_d  = 1'b0;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = br_nx;
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    bout_d  = br_nx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors, exhaustive sweep and multi-cycle corner sequences
module tb_serial_subtractor;
    localparam int W = 4;

    logic         clk, rst_n, start, ready, busy, done, bout;
    logic [W-1:0] sa, sb, diff;
    int           total = 0;
    int           bad = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    vec_t tbl[7];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (sa),
        .b    (sb),
        .ready(ready),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 3 * W) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, output int cyc);
        sa    = x;
        sb    = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
    endtask

    initial begin
        int c, c2, n;
        tbl[0] = '{4'd5,  4'd3, 4'd2,  1'b0};
        tbl[1] = '{4'd3,  4'd5, 4'd14, 1'b1};
        tbl[2] = '{4'd0,  4'd1, 4'd15, 1'b1};
        tbl[3] = '{4'd15, 4'd15, 4'd0, 1'b0};
        tbl[4] = '{4'd0,  4'd0, 4'd0,  1'b0};
        tbl[5] = '{4'd9,  4'd4, 4'd5,  1'b0};
        tbl[6] = '{4'd7,  4'd8, 4'd15, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        sa    = '0;
        sb    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {ready, busy, done, bout, diff}, {3'b100, 1'b0, 4'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].a, tbl[i].b, c);
            chk($sformatf("vec%0d_latency", i), c, W);
            chk($sformatf("vec%0d_result", i), {bout, diff}, {tbl[i].bo, tbl[i].d});
            chk($sformatf("vec%0d_done_ready", i), {ready, busy}, 2'b10);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_hold", i), {ready, done, bout, diff}, {2'b10, tbl[i].bo, tbl[i].d});
        end

        n = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                logic [W-1:0] ed;
                ed = W'((x - y) & 15);
                run_op(W'(x), W'(y), c);
                total++;
                if (c != W || {bout, diff} !== {(x < y), ed}) begin
                    bad++;
                    n++;
                    if (n < 10)
                        $display("FAIL sweep %0d-%0d: got lat=%0d bout=%0b diff=%0d expected lat=%0d bout=%0b diff=%0d",
                                 x, y, c, bout, diff, W, (x < y), ed);
                end
            end
        end
        @(posedge clk);
        #1;

        sa    = 4'd9;
        sb    = 4'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        sa    = 4'd1;
        sb    = 4'd2;
        chk("t4_busy_blocks", {ready, busy}, 2'b01);
        @(posedge clk);
        #1;
        start = 1'b0;
        sa    = '0;
        sb    = '0;
        wait_done(c);
        chk("t4_latency", c, W - 2);
        chk("t4_result", {bout, diff}, {1'b0, 4'd5});
        @(posedge clk);
        #1;
        chk("t4_back_idle", {ready, busy}, 2'b10);

        sa    = 4'd5;
        sb    = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        sa = 4'd7;
        sb = 4'd8;
        wait_done(c);
        chk("t5_latency1", c, W);
        chk("t5_result1", {bout, diff}, {1'b0, 4'd2});
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t5_reentry", {ready, busy, done}, 3'b010);
        wait_done(c2);
        chk("t5_gap", c2 + 1, W + 1);
        chk("t5_result2", {bout, diff}, {1'b1, 4'd15});
        @(posedge clk);
        #1;

        sa    = 4'd12;
        sb    = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", {ready, busy, done, bout, diff}, {3'b100, 1'b0, 4'd0});
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
        chk("t6_no_done", n, 0);
        run_op(4'd6, 4'd1, c);
        chk("t6_latency", c, W);
        chk("t6_result", {bout, diff}, {1'b0, 4'd5});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
